// File: rtl/rnn_pkg.sv
// Shared constants, types and helpers for the RNN gain path.
//   EBAND      : band edges in 4-bin units (eband5ms layout)
//   RECIP      : Q0.16 per-bin fraction step, round(65536 / (4 * band width))
//   band_last_j: last in-band bin offset of a band
//   clamp_gain : limit a Q8.8 gain to [0, 1.0]
//   sat_q88    : saturate a 32-bit value to signed 16-bit
package rnn_pkg;

    localparam int unsigned NB_BANDS  = 22;
    localparam int unsigned FREQ_SIZE = 481;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned FRAC_W    = 16;
    localparam int unsigned BAND_W    = 5;
    localparam int unsigned JCNT_W    = 7;
    localparam int unsigned BIN_W     = 9;

    localparam logic signed [DATA_W-1:0] ONE_16 = 16'sd256;

    localparam int unsigned EBAND [NB_BANDS] = '{
        0, 1, 2, 3, 4, 5, 6, 7, 8, 10, 12, 14, 16, 20, 24, 28, 34, 40, 48, 60, 78, 100
    };

    localparam logic [FRAC_W-1:0] RECIP [NB_BANDS-1] = '{
        16'd16384, 16'd16384, 16'd16384, 16'd16384, 16'd16384, 16'd16384, 16'd16384,
        16'd16384, 16'd8192,  16'd8192,  16'd8192,  16'd8192,  16'd4096,  16'd4096,
        16'd4096,  16'd2731,  16'd2731,  16'd2048,  16'd1365,  16'd910,   16'd745
    };

    typedef enum logic [0:0] {
        ST_LOAD  = 1'b0,
        ST_APPLY = 1'b1
    } bga_state_e;

    // Valid for b < NB_BANDS-1 only (the last band edge has no upper neighbour).
    function automatic logic [JCNT_W-1:0] band_last_j(input logic [BAND_W-1:0] b);
        int unsigned span;
        span = EBAND[b + BAND_W'(1)] - EBAND[b];
        return JCNT_W'(4 * span - 1);
    endfunction

    function automatic logic signed [DATA_W-1:0] clamp_gain(input logic signed [DATA_W-1:0] g);
        if (g < 16'sd0) begin
            return '0;
        end else if (g > ONE_16) begin
            return ONE_16;
        end
        return g;
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_q88(input logic signed [2*DATA_W-1:0] v);
        if (v > 32'sd32767) begin
            return 16'sh7FFF;
        end else if (v < -32'sd32768) begin
            return 16'sh8000;
        end
        return DATA_W'(v);
    endfunction

endpackage

// File: rtl/band_interp.sv
// Per-bin gain interpolation between adjacent band gains.
// Tracks which band the next bin falls in, the bin offset inside that band and
// the Q0.16 fraction (accumulated, not multiplied), and forms the interpolated gain.
// Ports:
//   clk, rst  : clock, synchronous active-low reset
//   clear_i   : return to band 0 (frame end)
//   adv_i     : a bin was consumed this cycle; step to the next bin
//   g_lo_i    : gain of the current band
//   g_hi_i    : gain of the next band
//   band_o    : band index of the current bin
//   gk_c_o    : interpolated gain for the current bin (combinational)
module band_interp
    import rnn_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     adv_i,
    input  logic signed [DATA_W-1:0] g_lo_i,
    input  logic signed [DATA_W-1:0] g_hi_i,
    output logic [BAND_W-1:0]        band_o,
    output logic signed [DATA_W-1:0] gk_c_o
);

    localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(NB_BANDS - 1);

    logic [BAND_W-1:0]       band_q, band_d;
    logic [JCNT_W-1:0]       j_q, j_d;
    logic [FRAC_W-1:0]       frac_q, frac_d;
    logic [BAND_W-1:0]       ridx;
    logic signed [DATA_W:0]  diff;
    logic signed [32:0]      prod;
    logic signed [32:0]      gk_wide;

    always_ff @(posedge clk) begin
        if (!rst) begin
            band_q <= '0;
            j_q    <= '0;
            frac_q <= '0;
        end else begin
            band_q <= band_d;
            j_q    <= j_d;
            frac_q <= frac_d;
        end
    end

    // Band walk: bins above the last band edge park in LAST_BAND (gain forced to 0).
    always_comb begin
        band_d = band_q;
        j_d    = j_q;
        frac_d = frac_q;
        ridx   = (band_q == LAST_BAND) ? LAST_BAND - BAND_W'(1) : band_q;
        if (clear_i) begin
            band_d = '0;
            j_d    = '0;
            frac_d = '0;
        end else if (adv_i && (band_q != LAST_BAND)) begin
            if (j_q == band_last_j(ridx)) begin
                band_d = band_q + BAND_W'(1);
                j_d    = '0;
                frac_d = '0;
            end else begin
                j_d    = j_q + JCNT_W'(1);
                frac_d = frac_q + RECIP[ridx];
            end
        end
    end

    // gk = g_lo + ((g_hi - g_lo) * frac) >>> 16, in 33-bit signed.
    always_comb begin
        diff    = (DATA_W + 1)'(g_hi_i) - (DATA_W + 1)'(g_lo_i);
        prod    = 33'(diff) * 33'($signed({1'b0, frac_q}));
        gk_wide = 33'(g_lo_i) + (prod >>> FRAC_W);
        gk_c_o  = (band_q == LAST_BAND) ? '0 : DATA_W'(gk_wide);
    end

    assign band_o = band_q;

endmodule

// File: rtl/band_gain_apply.sv
// Applies one frame of RNN band gains to a stream of complex spectrum bins.
// LOAD collects NB_BANDS Q8.8 gains (clamped to [0,1.0]); APPLY streams FREQ_SIZE
// bins, each scaled by its interpolated gain, into a single output register.
// Ports:
//   clk, rst                          : clock, synchronous active-low reset
//   gain_valid/gain_ready/gain_data   : band gain input, band 0 first
//   bin_valid/bin_ready/bin_re/bin_im : spectrum bin input (Q8.8)
//   out_valid/out_ready/out_re/out_im : gained bin output (Q8.8)
//   out_last                          : marks the final bin of a frame
module band_gain_apply
    import rnn_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     gain_valid,
    output logic                     gain_ready,
    input  logic signed [DATA_W-1:0] gain_data,
    input  logic                     bin_valid,
    output logic                     bin_ready,
    input  logic signed [DATA_W-1:0] bin_re,
    input  logic signed [DATA_W-1:0] bin_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_re,
    output logic signed [DATA_W-1:0] out_im,
    output logic                     out_last
);

    localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(NB_BANDS - 1);
    localparam logic [BIN_W-1:0]  LAST_BIN  = BIN_W'(FREQ_SIZE - 1);
    localparam logic [BIN_W-1:0]  ALL_BINS  = BIN_W'(FREQ_SIZE);

    bga_state_e               state_q, state_d;
    logic [BAND_W-1:0]        gcnt_q, gcnt_d;
    logic [BIN_W-1:0]         bcnt_q, bcnt_d;
    logic signed [DATA_W-1:0] g_q [NB_BANDS];
    logic signed [DATA_W-1:0] g_d [NB_BANDS];
    logic                     gain_ready_q, gain_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q, out_last_d;
    logic signed [DATA_W-1:0] out_re_q, out_re_d;
    logic signed [DATA_W-1:0] out_im_q, out_im_d;

    logic                     gain_acc;
    logic                     bin_acc;
    logic                     out_xfer;
    logic                     interp_clr;
    logic [BAND_W-1:0]        band;
    logic [BAND_W-1:0]        band_hi;
    logic signed [DATA_W-1:0] gk_c;
    logic signed [2*DATA_W-1:0] prod_re;
    logic signed [2*DATA_W-1:0] prod_im;

    band_interp u_interp (
        .clk     (clk),
        .rst     (rst),
        .clear_i (interp_clr),
        .adv_i   (bin_acc),
        .g_lo_i  (g_q[band]),
        .g_hi_i  (g_q[band_hi]),
        .band_o  (band),
        .gk_c_o  (gk_c)
    );

    assign band_hi   = (band == LAST_BAND) ? band : band + BAND_W'(1);
    assign gain_acc  = gain_valid && gain_ready_q;
    // Bin 480 closes intake; the frame then only drains the output register.
    assign bin_ready = (state_q == ST_APPLY) && (bcnt_q != ALL_BINS) && (!out_valid_q || out_ready);
    assign bin_acc   = bin_valid && bin_ready;
    assign out_xfer  = out_valid_q && out_ready;
    assign prod_re   = (2*DATA_W)'(bin_re) * (2*DATA_W)'(gk_c);
    assign prod_im   = (2*DATA_W)'(bin_im) * (2*DATA_W)'(gk_c);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_LOAD;
            gcnt_q       <= '0;
            bcnt_q       <= '0;
            g_q          <= '{default: '0};
            gain_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_re_q     <= '0;
            out_im_q     <= '0;
        end else begin
            state_q      <= state_d;
            gcnt_q       <= gcnt_d;
            bcnt_q       <= bcnt_d;
            g_q          <= g_d;
            gain_ready_q <= gain_ready_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_re_q     <= out_re_d;
            out_im_q     <= out_im_d;
        end
    end

    // Next-state, gain capture and output register update.
    always_comb begin
        state_d      = state_q;
        gcnt_d       = gcnt_q;
        bcnt_d       = bcnt_q;
        g_d          = g_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_re_d     = out_re_q;
        out_im_d     = out_im_q;
        interp_clr   = 1'b0;
        gain_ready_d = 1'b0;

        case (state_q)
            ST_LOAD: begin
                if (gain_acc) begin
                    g_d[gcnt_q] = clamp_gain(gain_data);
                    if (gcnt_q == LAST_BAND) begin
                        gcnt_d  = '0;
                        state_d = ST_APPLY;
                    end else begin
                        gcnt_d = gcnt_q + BAND_W'(1);
                    end
                end
            end
            ST_APPLY: begin
                if (out_xfer) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        state_d    = ST_LOAD;
                        bcnt_d     = '0;
                        interp_clr = 1'b1;
                    end
                end
                // A new bin may load in the same cycle the old output leaves.
                if (bin_acc) begin
                    out_valid_d = 1'b1;
                    out_last_d  = (bcnt_q == LAST_BIN);
                    out_re_d    = sat_q88(prod_re >>> 8);
                    out_im_d    = sat_q88(prod_im >>> 8);
                    bcnt_d      = bcnt_q + BIN_W'(1);
                end
            end
            default: state_d = ST_LOAD;
        endcase

        gain_ready_d = (state_d == ST_LOAD);
    end

    assign gain_ready = gain_ready_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_re     = out_re_q;
    assign out_im     = out_im_q;

endmodule

// File: tb/tb_band_gain_apply.sv
// Directed and table-driven bench for band_gain_apply.
module tb_band_gain_apply;

    localparam int NB = 22;
    localparam int NF = 481;

    logic               clk = 1'b0;
    logic               rst;
    logic               gain_valid;
    logic               gain_ready;
    logic signed [15:0] gain_data;
    logic               bin_valid;
    logic               bin_ready;
    logic signed [15:0] bin_re;
    logic signed [15:0] bin_im;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_re;
    logic signed [15:0] out_im;
    logic               out_last;

    always #5 clk = ~clk;

    band_gain_apply dut (
        .clk        (clk),
        .rst        (rst),
        .gain_valid (gain_valid),
        .gain_ready (gain_ready),
        .gain_data  (gain_data),
        .bin_valid  (bin_valid),
        .bin_ready  (bin_ready),
        .bin_re     (bin_re),
        .bin_im     (bin_im),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_re     (out_re),
        .out_im     (out_im),
        .out_last   (out_last)
    );

    int n_cmp = 0;
    int n_err = 0;

    int eb [NB] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 10, 12, 14, 16, 20, 24, 28, 34, 40, 48, 60, 78, 100};
    int gin [NB];
    int gcl [NB];
    int re_in [NF];
    int im_in [NF];
    int exp_re [NF];
    int exp_im [NF];
    int cap_re [NF];
    int cap_im [NF];
    int cap_last [NF];

    typedef struct {
        int k;
        int re;
        int im;
        int last;
    } vec_t;
    vec_t tbl [13];

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    function automatic int clampg(input int v);
        if (v < 0) return 0;
        if (v > 256) return 256;
        return v;
    endfunction

    // Reference gain: explicit band search and frac = j*recip.
    function automatic int model_gk(input int k);
        int i, w, recip, j, d;
        if (k >= 4 * eb[NB-1]) return 0;
        i = 0;
        for (int b = 0; b < NB - 1; b++) if (k >= 4 * eb[b]) i = b;
        w     = eb[i+1] - eb[i];
        recip = (65536 + 2 * w) / (4 * w);
        j     = k - 4 * eb[i];
        d     = gcl[i+1] - gcl[i];
        return gcl[i] + ((d * (j * recip)) >>> 16);
    endfunction

    function automatic int model_mul(input int x, input int gk);
        int p;
        p = (x * gk) >>> 8;
        if (p > 32767) p = 32767;
        if (p < -32768) p = -32768;
        return p;
    endfunction

    task automatic model_frame();
        int gk;
        for (int k = 0; k < NF; k++) begin
            gk        = model_gk(k);
            exp_re[k] = model_mul(re_in[k], gk);
            exp_im[k] = model_mul(im_in[k], gk);
        end
    endtask

    task automatic send_gains();
        int i   = 0;
        int cyc = 0;
        for (int b = 0; b < NB; b++) gcl[b] = clampg(gin[b]);
        while (i < NB && cyc < 300) begin
            @(negedge clk);
            gain_valid = 1'b1;
            gain_data  = 16'(gin[i]);
            #1;
            if (gain_ready) i++;
            cyc++;
        end
        @(negedge clk);
        gain_valid = 1'b0;
        check("gains_loaded", i, NB);
    endtask

    // mode 0: always ready; 1: random valid/ready; 2: 5-cycle stall on bin 150.
    task automatic run_frame(input int mode, input int limit, input bit stray);
        int sent   = 0;
        int got    = 0;
        int cyc    = 0;
        int stalls = 0;
        bit acc    = 1'b0;
        bin_valid = 1'b0;
        while (got < limit && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            if (!bin_valid || acc) begin
                if (sent < NF && (mode != 1 || $urandom_range(0, 3) != 0)) begin
                    bin_valid = 1'b1;
                    bin_re    = 16'(re_in[sent]);
                    bin_im    = 16'(im_in[sent]);
                end else begin
                    bin_valid = 1'b0;
                end
            end
            gain_valid = stray;
            gain_data  = 16'sd0;
            if (mode == 2 && got == 150 && stalls < 5) out_ready = 1'b0;
            else if (mode == 1) out_ready = ($urandom_range(0, 2) != 0);
            else out_ready = 1'b1;
            #1;
            if (stray) check("stray_gain_ready", int'(gain_ready), 0);
            if (mode == 2 && got == 150 && stalls < 5) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_re", int'(out_re), exp_re[150]);
                check("stall_im", int'(out_im), exp_im[150]);
                check("stall_bin_ready", int'(bin_ready), 0);
                stalls++;
            end
            acc = bin_valid && bin_ready;
            if (acc) sent++;
            if (out_valid && out_ready) begin
                cap_re[got]   = int'(out_re);
                cap_im[got]   = int'(out_im);
                cap_last[got] = int'(out_last);
                got++;
            end
        end
        gain_valid = 1'b0;
        check("frame_outputs", got, limit);
    endtask

    task automatic check_frame(input string tag);
        for (int k = 0; k < NF; k++) begin
            check($sformatf("%s_re[%0d]", tag, k), cap_re[k], exp_re[k]);
            check($sformatf("%s_im[%0d]", tag, k), cap_im[k], exp_im[k]);
            check($sformatf("%s_last[%0d]", tag, k), cap_last[k], (k == NF - 1) ? 1 : 0);
        end
    endtask

    task automatic check_back_in_load(input string tag);
        @(negedge clk);
        #1;
        check({tag, "_gain_ready"}, int'(gain_ready), 1);
        check({tag, "_out_valid"}, int'(out_valid), 0);
    endtask

    task automatic random_frame_inputs();
        for (int b = 0; b < NB; b++) gin[b] = int'($urandom_range(0, 400)) - 50;
        for (int k = 0; k < NF; k++) begin
            re_in[k] = int'($urandom_range(0, 65535)) - 32768;
            im_in[k] = int'($urandom_range(0, 65535)) - 32768;
        end
        for (int b = 0; b < NB; b++) gcl[b] = clampg(gin[b]);
        model_frame();
    endtask

    initial begin
        tbl[0]  = '{0,   0,     0,      0};
        tbl[1]  = '{2,   128,   -128,   0};
        tbl[2]  = '{4,   256,   -256,   0};
        tbl[3]  = '{20,  32767, -32768, 0};
        tbl[4]  = '{60,  128,   -128,   0};
        tbl[5]  = '{63,  32,    -32,    0};
        tbl[6]  = '{64,  0,     0,      0};
        tbl[7]  = '{72,  128,   -128,   0};
        tbl[8]  = '{79,  240,   -240,   0};
        tbl[9]  = '{80,  256,   -256,   0};
        tbl[10] = '{400, 0,     0,      0};
        tbl[11] = '{479, 0,     0,      0};
        tbl[12] = '{480, 0,     0,      1};

        rst        = 1'b0;
        gain_valid = 1'b0;
        gain_data  = '0;
        bin_valid  = 1'b0;
        bin_re     = '0;
        bin_im     = '0;
        out_ready  = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_gain_ready", int'(gain_ready), 0);
        check("rst_bin_ready", int'(bin_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_re", int'(out_re), 0);
        check("rst_out_im", int'(out_im), 0);
        check("rst_out_last", int'(out_last), 0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_gain_ready", int'(gain_ready), 1);

        // Bins offered during LOAD are not taken
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bin_valid = 1'b1;
            bin_re    = 16'sd123;
            #1;
            check("load_bin_ready", int'(bin_ready), 0);
        end
        @(negedge clk);
        bin_valid = 1'b0;

        // Frame 1: unity gains, stray gain_valid during APPLY
        for (int b = 0; b < NB; b++) gin[b] = 256;
        for (int k = 0; k < NF; k++) begin
            re_in[k]  = 100;
            im_in[k]  = -100;
            exp_re[k] = (k < 400) ? 100 : 0;
            exp_im[k] = (k < 400) ? -100 : 0;
        end
        send_gains();
        run_frame(0, NF, 1'b1);
        check_frame("f1");
        check_back_in_load("f1");

        // Frame 2: clamped gains, band-12 ramp, full-scale bin, stalled output
        for (int b = 0; b < NB; b++) gin[b] = 256;
        gin[0]  = -5;
        gin[1]  = 300;
        gin[12] = 0;
        for (int k = 0; k < NF; k++) begin
            re_in[k] = 256;
            im_in[k] = -256;
        end
        re_in[20] = 32767;
        im_in[20] = -32768;
        for (int b = 0; b < NB; b++) gcl[b] = clampg(gin[b]);
        model_frame();
        send_gains();
        run_frame(2, NF, 1'b0);
        for (int t = 0; t < 13; t++) begin
            check($sformatf("tbl_re[%0d]", tbl[t].k), cap_re[tbl[t].k], tbl[t].re);
            check($sformatf("tbl_im[%0d]", tbl[t].k), cap_im[tbl[t].k], tbl[t].im);
            check($sformatf("tbl_last[%0d]", tbl[t].k), cap_last[tbl[t].k], tbl[t].last);
        end
        check_frame("f2");
        check_back_in_load("f2");

        // Frame 3: reset around bin 200, then a clean frame
        random_frame_inputs();
        send_gains();
        run_frame(0, 200, 1'b0);
        @(negedge clk);
        rst       = 1'b0;
        bin_valid = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_last", int'(out_last), 0);
        check("midrst_out_re", int'(out_re), 0);
        check("midrst_bin_ready", int'(bin_ready), 0);
        check("midrst_gain_ready", int'(gain_ready), 0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_release_gain_ready", int'(gain_ready), 1);
        random_frame_inputs();
        send_gains();
        run_frame(0, NF, 1'b0);
        check_frame("f3");
        check_back_in_load("f3");

        // Frames 4-6: random gains, data and handshakes, back to back
        for (int f = 0; f < 3; f++) begin
            random_frame_inputs();
            send_gains();
            run_frame(1, NF, 1'b0);
            check_frame($sformatf("rnd%0d", f));
            check_back_in_load($sformatf("rnd%0d", f));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
